// File: rtl/reorder_buffer_pkg.sv
// Shared ROB types: entry state encoding, data/register widths, lookup result.
// Used by the reservation-station, CDB and register-file blocks.
package reorder_buffer_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2
  } entry_state_e;

  typedef struct packed {
    logic              ready;
    logic [DATA_W-1:0] value;
  } lookup_t;

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocate, CDB completion, in-order registered commit.
// Ports: alloc_* issue side, cdb_* broadcast, q_* operand lookup, commit_* retire.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alloc_req,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic [TAG_W-1:0]  alloc_tag,
  output logic              rob_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic [TAG_W-1:0]  q_tag_j,
  input  logic [TAG_W-1:0]  q_tag_k,
  output logic              q_ready_j,
  output logic              q_ready_k,
  output logic [DATA_W-1:0] q_value_j,
  output logic [DATA_W-1:0] q_value_k,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_value,
  output logic [TAG_W-1:0]  commit_tag
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
  localparam logic [TAG_W-1:0] MAX_TAG = TAG_W'(DEPTH);
  localparam logic [TAG_W-1:0] ONE_TAG = TAG_W'(1);

  entry_state_e      r_state [DEPTH];
  logic [REG_W-1:0]  r_dest  [DEPTH];
  logic [DATA_W-1:0] r_value [DEPTH];

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              r_commit_valid;
  logic [REG_W-1:0]  r_commit_dest;
  logic [DATA_W-1:0] r_commit_value;
  logic [TAG_W-1:0]  r_commit_tag;

  logic              w_full;
  logic              w_alloc;
  logic              w_commit;
  logic              w_cdb_hit;
  logic [PTR_W-1:0]  w_cdb_idx;
  lookup_t           w_look_j;
  lookup_t           w_look_k;

  function automatic logic [PTR_W-1:0] f_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic f_in_range(
    input logic [TAG_W-1:0] t
  );
    return (t != '0) && (t <= MAX_TAG);
  endfunction

  // Tags are index + 1 so that tag 0 can mean "value ready".
  function automatic logic [PTR_W-1:0] f_idx(
    input logic [TAG_W-1:0] t
  );
    return PTR_W'(t - ONE_TAG);
  endfunction

  function automatic logic [TAG_W-1:0] f_tag(
    input logic [PTR_W-1:0] p
  );
    return TAG_W'(p) + ONE_TAG;
  endfunction

  // Stored DONE value wins over the same-cycle CDB bypass.
  function automatic lookup_t f_lookup(
    input logic [TAG_W-1:0] t
  );
    lookup_t r;
    r.ready = 1'b0;
    r.value = '0;
    if (t == '0) begin
      r.ready = 1'b1;
    end else if (f_in_range(t) &&
                 r_state[f_idx(t)] == ST_DONE) begin
      r.ready = 1'b1;
      r.value = r_value[f_idx(t)];
    end else if (cdb_valid && cdb_tag == t) begin
      r.ready = 1'b1;
      r.value = cdb_value;
    end
    return r;
  endfunction

  always_comb begin
    w_full    = (r_count == FULL_C);
    w_alloc   = alloc_req && !w_full;
    w_commit  = (r_state[r_head] == ST_DONE);
    w_cdb_idx = f_idx(cdb_tag);
    w_cdb_hit = cdb_valid && f_in_range(cdb_tag) &&
                (r_state[w_cdb_idx] == ST_BUSY);
    w_look_j  = f_lookup(q_tag_j);
    w_look_k  = f_lookup(q_tag_k);
  end

  assign alloc_tag    = f_tag(r_tail);
  assign rob_full     = w_full;
  assign q_ready_j    = w_look_j.ready;
  assign q_value_j    = w_look_j.value;
  assign q_ready_k    = w_look_k.ready;
  assign q_value_k    = w_look_k.value;
  assign commit_valid = r_commit_valid;
  assign commit_dest  = r_commit_dest;
  assign commit_value = r_commit_value;
  assign commit_tag   = r_commit_tag;

  // Alloc targets an EMPTY tail, CDB a BUSY entry and commit a DONE
  // head, so the three writes never land on the same entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= ST_EMPTY;
        r_dest[i]  <= '0;
        r_value[i] <= '0;
      end
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_commit_valid <= 1'b0;
      r_commit_dest  <= '0;
      r_commit_value <= '0;
      r_commit_tag   <= '0;
    end else begin
      if (w_alloc) begin
        r_state[r_tail] <= ST_BUSY;
        r_dest[r_tail]  <= alloc_dest;
        r_tail          <= f_inc(r_tail);
      end

      if (w_cdb_hit) begin
        r_state[w_cdb_idx] <= ST_DONE;
        r_value[w_cdb_idx] <= cdb_value;
      end

      if (w_commit) begin
        r_state[r_head] <= ST_EMPTY;
        r_head          <= f_inc(r_head);
        r_commit_valid  <= 1'b1;
        r_commit_dest   <= r_dest[r_head];
        r_commit_value  <= r_value[r_head];
        r_commit_tag    <= f_tag(r_head);
      end else begin
        r_commit_valid  <= 1'b0;
        r_commit_dest   <= '0;
        r_commit_value  <= '0;
        r_commit_tag    <= '0;
      end

      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer against a queue-based model.
// Directed scenarios plus a randomized run.
module tb_reorder_buffer;

  localparam int DEPTH = 8;
  localparam int TAG_W = 4;

  logic        clock;
  logic        reset_n;
  logic        alloc_req;
  logic [2:0]  alloc_dest;
  logic [3:0]  alloc_tag;
  logic        rob_full;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [15:0] cdb_value;
  logic [3:0]  q_tag_j;
  logic [3:0]  q_tag_k;
  logic        q_ready_j;
  logic        q_ready_k;
  logic [15:0] q_value_j;
  logic [15:0] q_value_k;
  logic        commit_valid;
  logic [2:0]  commit_dest;
  logic [15:0] commit_value;
  logic [3:0]  commit_tag;

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .alloc_req(alloc_req), .alloc_dest(alloc_dest),
    .alloc_tag(alloc_tag), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value),
    .q_tag_j(q_tag_j), .q_tag_k(q_tag_k),
    .q_ready_j(q_ready_j), .q_ready_k(q_ready_k),
    .q_value_j(q_value_j), .q_value_k(q_value_k),
    .commit_valid(commit_valid), .commit_dest(commit_dest),
    .commit_value(commit_value), .commit_tag(commit_tag)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int tag;
    int dest;
    bit done;
    int value;
  } ent_t;

  typedef struct {
    int tag;
    int dest;
    int value;
  } got_t;

  ent_t mq[$];
  got_t got[$];
  int   m_tail;
  int   e_cv, e_cd, e_cval, e_ctag;
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [16:0] m_lookup(int t);
    if (t == 0) return {1'b1, 16'h0};
    foreach (mq[i])
      if (mq[i].tag == t && mq[i].done)
        return {1'b1, 16'(mq[i].value)};
    if (cdb_valid && int'(cdb_tag) == t)
      return {1'b1, cdb_value};
    return {1'b0, 16'h0};
  endfunction

  task automatic drive(input bit a, input int d,
                       input bit cv, input int ct,
                       input int val);
    alloc_req  = a;
    alloc_dest = 3'(d);
    cdb_valid  = cv;
    cdb_tag    = 4'(ct);
    cdb_value  = 16'(val);
  endtask

  task automatic tick();
    bit full, com;
    @(posedge clock);
    full = (mq.size() == DEPTH);
    com  = (mq.size() > 0) && mq[0].done;
    if (com) begin
      e_cv = 1; e_cd = mq[0].dest;
      e_cval = mq[0].value; e_ctag = mq[0].tag;
    end else begin
      e_cv = 0; e_cd = 0; e_cval = 0; e_ctag = 0;
    end
    if (cdb_valid)
      foreach (mq[i])
        if (mq[i].tag == int'(cdb_tag) && !mq[i].done) begin
          mq[i].done  = 1;
          mq[i].value = int'(cdb_value);
        end
    if (com) void'(mq.pop_front());
    if (alloc_req && !full) begin
      mq.push_back('{m_tail + 1, int'(alloc_dest), 0, 0});
      m_tail = (m_tail + 1) % DEPTH;
    end
    #1;
    if (commit_valid)
      got.push_back('{int'(commit_tag), int'(commit_dest),
                      int'(commit_value)});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    q_tag_j = '0;
    q_tag_k = '0;
    @(posedge clock);
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    mq.delete();
    got.delete();
    m_tail = 0;
    e_cv = 0; e_cd = 0; e_cval = 0; e_ctag = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1, 5, 1, 1, 16'h1234);
    q_tag_j = '0;
    q_tag_k = '0;
    #2;
    n_checks++;
    if (rob_full !== 1'b0 || alloc_tag !== 4'd1) begin
      n_errors++;
      $display("FAIL reset_ptr full=%0b tag=%0d want 0 1",
               rob_full, alloc_tag);
    end
    n_checks++;
    if (commit_valid !== 1'b0 || commit_tag !== 4'd0 ||
        commit_dest !== 3'd0 || commit_value !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_commit v=%0b t=%0d d=%0d x=%0h want 0",
               commit_valid, commit_tag, commit_dest, commit_value);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (alloc_tag !== 4'd1 || commit_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_hold tag=%0d cv=%0b want 1 0",
               alloc_tag, commit_valid);
    end
    do_reset();
  endtask

  task automatic test_in_order();
    int d[3]   = '{1, 2, 3};
    int ct[3]  = '{3, 1, 2};
    int cvl[3] = '{30, 10, 20};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, d[i], 0, 0, 0);
      #1;
      n_checks++;
      if (alloc_tag !== 4'(i + 1)) begin
        n_errors++;
        $display("FAIL order_tag got %0d want %0d", alloc_tag, i + 1);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, ct[i], cvl[i]);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (got.size() != 3) begin
      n_errors++;
      $display("FAIL order_count got %0d want 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_checks++;
      if (got[i].tag != i + 1 || got[i].dest != i + 1 ||
          got[i].value != (i + 1) * 10) begin
        n_errors++;
        $display("FAIL order_commit%0d got t%0d d%0d v%0d want t%0d d%0d v%0d",
                 i, got[i].tag, got[i].dest, got[i].value,
                 i + 1, i + 1, (i + 1) * 10);
      end
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, (i + 3) % 8, 0, 0, 0);
      tick();
    end
    n_checks++;
    if (rob_full !== 1'b1) begin
      n_errors++;
      $display("FAIL full_set got %0b want 1", rob_full);
    end
    drive(1, 7, 0, 0, 0);
    #1;
    n_checks++;
    if (alloc_tag !== 4'd1) begin
      n_errors++;
      $display("FAIL full_tag got %0d want 1", alloc_tag);
    end
    tick();
    n_checks++;
    if (rob_full !== 1'b1 || commit_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL full_ninth full=%0b cv=%0b want 1 0",
               rob_full, commit_valid);
    end
    drive(1, 7, 1, 1, 16'h0011);
    tick();
    drive(1, 5, 0, 0, 0);
    tick();
    n_checks++;
    if (commit_valid !== 1'b1 || commit_tag !== 4'd1 ||
        commit_dest !== 3'd3 || commit_value !== 16'h0011) begin
      n_errors++;
      $display("FAIL simul_commit v=%0b t=%0d d=%0d x=%0h want 1 1 3 11",
               commit_valid, commit_tag, commit_dest, commit_value);
    end
    n_checks++;
    if (rob_full !== 1'b0 || alloc_tag !== 4'd1) begin
      n_errors++;
      $display("FAIL simul_refused full=%0b tag=%0d want 0 1",
               rob_full, alloc_tag);
    end
    tick();
    n_checks++;
    if (rob_full !== 1'b1 || alloc_tag !== 4'd2 ||
        commit_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL simul_accept full=%0b tag=%0d cv=%0b want 1 2 0",
               rob_full, alloc_tag, commit_valid);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    drive(1, 1, 0, 0, 0);
    tick();
    drive(1, 2, 0, 0, 0);
    tick();
    drive(0, 0, 1, 2, 16'h00AB);
    q_tag_j = 4'd2;
    q_tag_k = 4'd0;
    #1;
    n_checks++;
    if (q_ready_j !== 1'b1 || q_value_j !== 16'h00AB) begin
      n_errors++;
      $display("FAIL bypass_j rdy=%0b val=%0h want 1 ab",
               q_ready_j, q_value_j);
    end
    n_checks++;
    if (q_ready_k !== 1'b1 || q_value_k !== 16'h0) begin
      n_errors++;
      $display("FAIL bypass_k0 rdy=%0b val=%0h want 1 0",
               q_ready_k, q_value_k);
    end
    q_tag_k = 4'd1;
    #1;
    n_checks++;
    if (q_ready_k !== 1'b0) begin
      n_errors++;
      $display("FAIL bypass_busy rdy=%0b want 0", q_ready_k);
    end
    q_tag_k = 4'd0;
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (q_ready_j !== 1'b1 || q_value_j !== 16'h00AB) begin
      n_errors++;
      $display("FAIL bypass_stored rdy=%0b val=%0h want 1 ab",
               q_ready_j, q_value_j);
    end
  endtask

  task automatic test_spurious();
    int st[3] = '{0, 12, 2};
    got.delete();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, st[i], 16'h0055 + i);
      tick();
      n_checks++;
      if (commit_valid !== 1'b0 || q_value_j !== 16'h00AB) begin
        n_errors++;
        $display("FAIL spur_%0d cv=%0b val=%0h want 0 ab",
                 st[i], commit_valid, q_value_j);
      end
    end
    drive(0, 0, 1, 1, 16'h0011);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (got.size() != 2) begin
      n_errors++;
      $display("FAIL spur_count got %0d want 2", got.size());
    end else begin
      n_checks++;
      if (got[0].tag != 1 || got[0].value != 'h11 ||
          got[1].tag != 2 || got[1].value != 'hAB) begin
        n_errors++;
        $display("FAIL spur_commit got t%0d v%0h t%0d v%0h want 1 11 2 ab",
                 got[0].tag, got[0].value, got[1].tag, got[1].value);
      end
    end
  endtask

  task automatic test_random();
    int bt[$];
    logic [16:0] ej, ek;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bt.delete();
      foreach (mq[i]) if (!mq[i].done) bt.push_back(mq[i].tag);
      if (bt.size() > 0 && $urandom_range(0, 9) < 6)
        drive($urandom_range(0, 1) == 1, $urandom_range(0, 7), 1,
              bt[$urandom_range(0, bt.size() - 1)],
              $urandom_range(0, 65535));
      else
        drive($urandom_range(0, 1) == 1, $urandom_range(0, 7),
              $urandom_range(0, 3) == 0, $urandom_range(0, 15),
              $urandom_range(0, 65535));
      q_tag_j = 4'($urandom_range(0, 15));
      q_tag_k = 4'($urandom_range(0, 15));
      #1;
      ej = m_lookup(int'(q_tag_j));
      ek = m_lookup(int'(q_tag_k));
      n_checks++;
      if (rob_full !== (mq.size() == DEPTH) ||
          alloc_tag !== 4'(m_tail + 1)) begin
        n_errors++;
        $display("FAIL rnd_alloc c%0d full=%0b tag=%0d want %0b %0d",
                 c, rob_full, alloc_tag, mq.size() == DEPTH, m_tail + 1);
      end
      n_checks++;
      if ({q_ready_j, q_value_j} !== ej ||
          {q_ready_k, q_value_k} !== ek) begin
        n_errors++;
        $display("FAIL rnd_lookup c%0d j=%0h k=%0h want %0h %0h",
                 c, {q_ready_j, q_value_j}, {q_ready_k, q_value_k},
                 ej, ek);
      end
      tick();
      n_checks++;
      if (commit_valid !== 1'(e_cv) || commit_dest !== 3'(e_cd) ||
          commit_value !== 16'(e_cval) || commit_tag !== 4'(e_ctag)) begin
        n_errors++;
        $display("FAIL rnd_commit c%0d got %0b %0d %0h %0d want %0d %0d %0h %0d",
                 c, commit_valid, commit_dest, commit_value, commit_tag,
                 e_cv, e_cd, e_cval, e_ctag);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, i + 1, 0, 0, 0);
      tick();
    end
    drive(0, 0, 1, 1, 16'h0077);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (commit_valid !== 1'b1 || commit_value !== 16'h0077) begin
      n_errors++;
      $display("FAIL mid_pre cv=%0b val=%0h want 1 77",
               commit_valid, commit_value);
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (commit_valid !== 1'b0 || commit_dest !== 3'd0 ||
        commit_value !== 16'd0 || commit_tag !== 4'd0) begin
      n_errors++;
      $display("FAIL mid_async v=%0b d=%0d x=%0h t=%0d want 0",
               commit_valid, commit_dest, commit_value, commit_tag);
    end
    n_checks++;
    if (rob_full !== 1'b0 || alloc_tag !== 4'd1) begin
      n_errors++;
      $display("FAIL mid_ptr full=%0b tag=%0d want 0 1",
               rob_full, alloc_tag);
    end
    do_reset();
    drive(1, 4, 0, 0, 0);
    #1;
    n_checks++;
    if (alloc_tag !== 4'd1) begin
      n_errors++;
      $display("FAIL mid_first got %0d want 1", alloc_tag);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (alloc_tag !== 4'd2 || commit_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_after tag=%0d cv=%0b want 2 0",
               alloc_tag, commit_valid);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full_wrap();
    test_bypass();
    test_spurious();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of entries (2..15).
REQ-002 SHALL have parameter TAG_W, default 4, meaning tag width; tag 0 means "no producer / value ready".
REQ-003 SHALL have port clock  input  1  meaning the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  meaning asynchronous active-low reset.
REQ-005 SHALL have port alloc_req  input  1  meaning the instruction queue is issuing one instruction this cycle.
REQ-006 SHALL have port alloc_dest  input  3  meaning destination register of the issuing instruction.
REQ-007 SHALL have port alloc_tag  output  TAG_W  meaning tag assigned to the issuing instruction, equal to tail index + 1, combinational.
REQ-008 SHALL have port rob_full  output  1  meaning no free entry; issue must stall.
REQ-009 SHALL have port cdb_valid  input  1  meaning a CDB broadcast is present this cycle.
REQ-010 SHALL have port cdb_tag  input  TAG_W  meaning producer tag of the broadcast.
REQ-011 SHALL have port cdb_value  input  16  meaning broadcast result.
REQ-012 SHALL have ports q_tag_j and q_tag_k  input  TAG_W  meaning operand tags looked up by the reservation station.
REQ-013 SHALL have ports q_ready_j and q_ready_k  output  1  and q_value_j and q_value_k  output  16  meaning combinational operand lookup result.
REQ-014 SHALL have port commit_valid  output  1  meaning register-file write enable (habEscr side).
REQ-015 SHALL have ports commit_dest  output  3  and commit_value  output  16  meaning register-file write address and data.
REQ-016 SHALL have port commit_tag  output  TAG_W  meaning tag being retired, so register status can be cleared.

Function
REQ-017 SHALL keep, per entry, a state of EMPTY, BUSY or DONE, plus a 3-bit destination and a 16-bit value.
REQ-018 SHALL keep head and tail pointers that wrap from DEPTH-1 to 0, and a count from 0 to DEPTH.
REQ-019 SHALL assert rob_full iff count == DEPTH, computed from registered count only.
REQ-020 SHALL, on alloc_req with rob_full low, write entry[tail] as BUSY with alloc_dest, then advance tail and increment count.
REQ-021 SHALL ignore alloc_req while rob_full is high, including in a cycle where a commit frees an entry.
REQ-022 SHALL, on cdb_valid with cdb_tag in 1..DEPTH whose entry is BUSY, store cdb_value and set the entry to DONE.
REQ-023 SHALL ignore a broadcast with tag 0, tag > DEPTH, or a tag whose entry is EMPTY or DONE.
REQ-024 SHALL register the commit outputs: when entry[head] is DONE at a rising edge, commit_valid, commit_dest, commit_value and commit_tag are high and valid for exactly the following cycle, the entry becomes EMPTY, head advances and count decrements.
REQ-025 SHALL retire at most one entry per cycle and strictly in allocation order; a DONE entry behind a BUSY head waits.
REQ-026 SHALL give a 1-cycle minimum latency from a CDB write to the head entry until its commit_valid.
REQ-027 SHALL, when allocation and commit occur in the same cycle, leave count unchanged and update both pointers.
REQ-028 SHALL, for a lookup, return q_ready=1 and q_value=0 for tag 0; return q_ready=1 with the stored value for a DONE entry; return q_ready=1 with cdb_value when the tag matches the current cdb_tag and cdb_valid is high (same-cycle bypass); otherwise return q_ready=0.
REQ-029 SHALL drive commit_dest, commit_value and commit_tag to 0 whenever commit_valid is low.

Reset
REQ-030 SHALL, on reset_n low, immediately set all entries to EMPTY, head = tail = count = 0, and commit_valid, commit_dest, commit_value and commit_tag to 0, regardless of any operation in progress.
REQ-031 SHALL make rob_full = 0 and alloc_tag = 1 hold during reset and after reset.

Structure
REQ-032 SHALL place the entry-state encoding (EMPTY=0, BUSY=1, DONE=2), the 16-bit data width and the 3-bit register-address width in a shared package used by the reservation-station, CDB and register-file blocks.
REQ-033 SHALL be implemented as a single module with no sub-modules; the lookup logic may be one function that is instantiated twice.

Verification
REQ-034 SHALL verify in-order issue and commit: allocate dests 1, 2, 3 (tags 1, 2, 3); broadcast tag 3 = 30, then tag 1 = 10, then tag 2 = 20 -> commits appear in order (1,10), (2,20), (3,30), and commit for tag 3 occurs no earlier than for tag 2.
REQ-035 SHALL verify full and wrap-around: allocate 8 -> rob_full=1 and a 9th alloc is ignored; retire 1 and allocate again -> alloc_tag=1 (wrapped).
REQ-036 SHALL verify simultaneous events: full buffer, head DONE, alloc_req in the commit cycle -> alloc refused; next cycle alloc accepted and count is 8.
REQ-037 SHALL verify lookup bypass: tag 2 BUSY, cdb_valid with tag 2 = 0x00AB, q_tag_j=2 -> q_ready_j=1 and q_value_j=0x00AB in the same cycle; and q_tag_k=0 -> q_ready_k=1.
REQ-038 SHALL verify spurious broadcasts: a broadcast to tag 0, to tag 12, and to an already-DONE tag -> no state change and no extra commit.
REQ-039 SHALL verify reset mid-operation: assert reset_n low while 5 entries are BUSY and commit_valid is high -> outputs go to 0 asynchronously; after release, the first allocation returns tag 1.
